alarm_unit: RTL and testbench
=============================

// Module: alarm_unit
// PURPOSE
// Three-slot calendar alarm for the digital clock. Each slot stores a BCD date/time
// (year..second) and its Unix-epoch equivalent in seconds. ring is raised when the
// system seconds counter reaches an armed slot's time. Sits beside the timekeeping
// counter; drives the buzzer and the alarm display digits.
// PARAMETERS
// RING_SECONDS  60  counter ticks ring stays latched without cancel (auto-silence)
// PORTS
// clk                  in   1   system clock, all state on rising edge
// rst_n                in   1   asynchronous reset, active-high (1 = reset) despite the name
// set                  in   1   store the *_bcd_in fields into slot selected_alarm
// alarm_year_bcd_in    in   16  4-digit BCD year, valid 1970..2099
// alarm_month_bcd_in   in   8   BCD 01..12
// alarm_day_bcd_in     in   8   BCD 01..31
// alarm_hour_bcd_in    in   8   BCD 00..23
// alarm_minute_bcd_in  in   8   BCD 00..59
// alarm_second_bcd_in  in   8   BCD 00..59
// selected_alarm       in   2   slot index 0..2; 3 = no slot
// counter              in   64  current time, seconds since 1970-01-01 00:00:00 (UTC, no offset)
// cancel               in   1   silence all ringing slots
// alarm_hour_bcd       out  8   hour of slot selected_alarm
// alarm_minute_bcd     out  8   minute of slot selected_alarm
// alarm_second_bcd     out  8   second of slot selected_alarm
// ring                 out  1   1 while any slot is ringing
// BEHAVIOUR
// - Reset: all slots BCD = 0, target = 0, armed = 0, ringing = 0, timers = 0; ring = 0.
// - Store: each clk edge with set=1 and selected_alarm<3 writes the BCD fields, target
//   seconds, armed=1 and clears that slot's ringing/timer. Level-sensitive; a held set rewrites
//   identical values. selected_alarm=3 with set=1 does nothing.
// - Conversion (combinational from inputs, registered at store):
//   days = 365*(Y-1970) + leap years in [1970,Y) + cumulative days before month M
//   (+1 if M>2 and Y leap) + (D-1); leap = (Y%4==0) over 1970..2099.
//   target = days*86400 + h*3600 + m*60 + s, 64-bit unsigned. Out-of-range BCD: undefined
//   target, no hang.
// - Trigger: slot k starts ringing at the edge where armed_k=1 and counter==target_k. ring
//   is registered: high the cycle after the match. Equality only; counter jumping past
//   target misses it. Slot stays armed afterwards (fires again only if counter re-equals target).
// - Ringing slot: timer loads RING_SECONDS at trigger and decrements each edge where counter
//   differs from previous edge's counter. Slot stops ringing at timer 0.
// - cancel=1 on an edge clears ringing/timers of all slots. Cancel has priority over a trigger
//   in the same cycle. Slots are not disarmed.
// - Several slots may ring at once. ring = OR of ringing flags.
// - Display outputs: combinational mux of the stored BCD of slot selected_alarm. 8'h00 when
//   selected_alarm=3. Reset value 8'h00.
// - Reset mid-ring: ring drops asynchronously, all slots disarmed.
// TESTING
// - Reset, hold rst_n=1: ring=0, display = 00:00:00 for every selected_alarm; counter==0 does
//   not ring (unarmed).
// - Set slot0=2024-01-01 00:00:00, slot1=..00:00:20, slot2=..00:00:30. Select 0/1/2 ->
//   display 00:00:00 / 00:00:20 / 00:00:30. Select 3 -> 00:00:00.
// - counter=1704067199 incrementing per cycle: ring rises the cycle after counter=1704067200;
//   still high when slot1 (1704067220) and slot2 (1704067230) match.
// - cancel=1 one cycle while ringing -> ring=0 next cycle. Slot2 match after cancel -> ring=1
//   again.
// - No cancel, RING_SECONDS=5, single slot -> ring high exactly 5 counter ticks then 0.
// - counter jumps 1704067199 -> 1704067201 -> slot0 never rings. set on a ringing slot
//   clears its ring. Async reset during ring -> ring=0 immediately.

Source files
------------

// File: rtl/alarm_unit.sv
// ============================================================================
// Module   : alarm_unit
// Brief    : Three-slot BCD calendar alarm, epoch-second trigger, auto-silence
// Revision : 1.0
// ============================================================================
`default_nettype none

module alarm_unit #(
    parameter int RING_SECONDS = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set,
    input  logic [15:0] alarm_year_bcd_in,
    input  logic [7:0]  alarm_month_bcd_in,
    input  logic [7:0]  alarm_day_bcd_in,
    input  logic [7:0]  alarm_hour_bcd_in,
    input  logic [7:0]  alarm_minute_bcd_in,
    input  logic [7:0]  alarm_second_bcd_in,
    input  logic [1:0]  selected_alarm,
    input  logic [63:0] counter,
    input  logic        cancel,
    output logic [7:0]  alarm_hour_bcd,
    output logic [7:0]  alarm_minute_bcd,
    output logic [7:0]  alarm_second_bcd,
    output logic        ring
);

    localparam int            TW          = (RING_SECONDS < 1) ? 1 : $clog2(RING_SECONDS + 1);
    localparam logic [TW-1:0] c_RING_LOAD = TW'(RING_SECONDS);

    function automatic logic [6:0] f_bcd8(input logic [7:0] b);
        return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
    endfunction

    logic [13:0] w_year;
    logic [13:0] w_years_since;
    logic [13:0] w_leaps;
    logic [6:0]  w_month;
    logic [6:0]  w_day;
    logic [8:0]  w_cum_days;
    logic        w_leap_adj;
    logic [31:0] w_days;
    logic [63:0] w_target;
    logic        w_tick;
    logic [63:0] r_prev_counter;
    logic [2:0]  w_ringing;
    logic [7:0]  w_hour [0:2];
    logic [7:0]  w_min  [0:2];
    logic [7:0]  w_sec  [0:2];

    assign w_year = 14'(alarm_year_bcd_in[15:12]) * 14'd1000
                  + 14'(alarm_year_bcd_in[11:8])  * 14'd100
                  + 14'(alarm_year_bcd_in[7:4])   * 14'd10
                  + 14'(alarm_year_bcd_in[3:0]);
    assign w_month       = f_bcd8(alarm_month_bcd_in);
    assign w_day         = f_bcd8(alarm_day_bcd_in);
    assign w_years_since = w_year - 14'd1970;
    // Leap years in [1970, Y) are 1972, 1976, ...; every 4th year within 1970..2099
    assign w_leaps       = (w_year - 14'd1969) >> 2;
    assign w_leap_adj    = (w_year[1:0] == 2'b00) && (w_month > 7'd2);

    always_comb begin
        w_cum_days = 9'd0;
        case (w_month)
            7'd2:    w_cum_days = 9'd31;
            7'd3:    w_cum_days = 9'd59;
            7'd4:    w_cum_days = 9'd90;
            7'd5:    w_cum_days = 9'd120;
            7'd6:    w_cum_days = 9'd151;
            7'd7:    w_cum_days = 9'd181;
            7'd8:    w_cum_days = 9'd212;
            7'd9:    w_cum_days = 9'd243;
            7'd10:   w_cum_days = 9'd273;
            7'd11:   w_cum_days = 9'd304;
            7'd12:   w_cum_days = 9'd334;
            default: w_cum_days = 9'd0;
        endcase
    end

    assign w_days   = 32'(w_years_since) * 32'd365 + 32'(w_leaps) + 32'(w_cum_days)
                    + 32'(w_leap_adj) + 32'(w_day) - 32'd1;
    assign w_target = 64'(w_days) * 64'd86400
                    + 64'(f_bcd8(alarm_hour_bcd_in))   * 64'd3600
                    + 64'(f_bcd8(alarm_minute_bcd_in)) * 64'd60
                    + 64'(f_bcd8(alarm_second_bcd_in));

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) r_prev_counter <= 64'd0;
        else       r_prev_counter <= counter;
    end

    assign w_tick = (counter != r_prev_counter);

    for (genvar k = 0; k < 3; k++) begin : g_slot
        logic          w_store;
        logic          r_armed;
        logic          r_ringing;
        logic [TW-1:0] r_timer;
        logic [63:0]   r_target;
        logic [7:0]    r_hour;
        logic [7:0]    r_min;
        logic [7:0]    r_sec;

        assign w_store = set && (selected_alarm == 2'(k));

        // Priority: store, then cancel, then trigger, then tick-driven countdown
        always_ff @(posedge clk or posedge rst_n) begin
            if (rst_n) begin
                r_armed   <= 1'b0;
                r_ringing <= 1'b0;
                r_timer   <= '0;
                r_target  <= 64'd0;
                r_hour    <= 8'h00;
                r_min     <= 8'h00;
                r_sec     <= 8'h00;
            end else if (w_store) begin
                r_armed   <= 1'b1;
                r_ringing <= 1'b0;
                r_timer   <= '0;
                r_target  <= w_target;
                r_hour    <= alarm_hour_bcd_in;
                r_min     <= alarm_minute_bcd_in;
                r_sec     <= alarm_second_bcd_in;
            end else if (cancel) begin
                r_ringing <= 1'b0;
                r_timer   <= '0;
            end else if (r_armed && (counter == r_target)) begin
                r_ringing <= 1'b1;
                r_timer   <= c_RING_LOAD;
            end else if (w_tick && r_ringing) begin
                if (r_timer <= TW'(1)) begin
                    r_ringing <= 1'b0;
                    r_timer   <= '0;
                end else begin
                    r_timer <= r_timer - TW'(1);
                end
            end
        end

        assign w_ringing[k] = r_ringing;
        assign w_hour[k]    = r_hour;
        assign w_min[k]     = r_min;
        assign w_sec[k]     = r_sec;
    end

    always_comb begin
        alarm_hour_bcd   = 8'h00;
        alarm_minute_bcd = 8'h00;
        alarm_second_bcd = 8'h00;
        case (selected_alarm)
            2'd0: begin
                alarm_hour_bcd   = w_hour[0];
                alarm_minute_bcd = w_min[0];
                alarm_second_bcd = w_sec[0];
            end
            2'd1: begin
                alarm_hour_bcd   = w_hour[1];
                alarm_minute_bcd = w_min[1];
                alarm_second_bcd = w_sec[1];
            end
            2'd2: begin
                alarm_hour_bcd   = w_hour[2];
                alarm_minute_bcd = w_min[2];
                alarm_second_bcd = w_sec[2];
            end
            default: begin
                alarm_hour_bcd   = 8'h00;
                alarm_minute_bcd = 8'h00;
                alarm_second_bcd = 8'h00;
            end
        endcase
    end

    assign ring = |w_ringing;

endmodule

`default_nettype wire

// File: tb/tb_alarm_unit.sv
// ============================================================================
// Module   : tb_alarm_unit
// Brief    : Directed + random bench for alarm_unit (two instances: 60 and 5 ticks)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alarm_unit;

    logic        clk = 1'b0;
    logic        rst_n, set, cancel;
    logic [15:0] yb;
    logic [7:0]  mob, db, hb, mib, sb;
    logic [1:0]  sel;
    logic [63:0] cnt;
    logic [7:0]  h60, m60, s60, h5, m5, s5;
    logic        ring60, ring5;

    always #5 clk = ~clk;

    alarm_unit #(.RING_SECONDS(60)) dut (
        .clk(clk), .rst_n(rst_n), .set(set),
        .alarm_year_bcd_in(yb), .alarm_month_bcd_in(mob), .alarm_day_bcd_in(db),
        .alarm_hour_bcd_in(hb), .alarm_minute_bcd_in(mib), .alarm_second_bcd_in(sb),
        .selected_alarm(sel), .counter(cnt), .cancel(cancel),
        .alarm_hour_bcd(h60), .alarm_minute_bcd(m60), .alarm_second_bcd(s60), .ring(ring60)
    );

    alarm_unit #(.RING_SECONDS(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .set(set),
        .alarm_year_bcd_in(yb), .alarm_month_bcd_in(mob), .alarm_day_bcd_in(db),
        .alarm_hour_bcd_in(hb), .alarm_minute_bcd_in(mib), .alarm_second_bcd_in(sb),
        .selected_alarm(sel), .counter(cnt), .cancel(cancel),
        .alarm_hour_bcd(h5), .alarm_minute_bcd(m5), .alarm_second_bcd(s5), .ring(ring5)
    );

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          cy, cmo, cd, ch, cmi, cs;
    bit          m_armed [3];
    logic [63:0] m_tgt   [3];
    int          m_h [3], m_m [3], m_s [3];
    int          m_left [2][3];
    logic [63:0] m_prev;
    int          RS [2] = '{60, 5};

    function automatic bit is_leap(int y);
        return (y % 4) == 0;
    endfunction

    function automatic int mdays(int mo, int y);
        if (mo == 2) return is_leap(y) ? 29 : 28;
        if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
        return 31;
    endfunction

    function automatic logic [63:0] epoch(int y, int mo, int d, int h, int mi, int s);
        longint days = 0;
        for (int yy = 1970; yy < y; yy++) days += is_leap(yy) ? 366 : 365;
        for (int mm = 1; mm < mo; mm++) days += mdays(mm, y);
        days += d - 1;
        return 64'(days * 86400 + h * 3600 + mi * 60 + s);
    endfunction

    function automatic logic [7:0] bcd8(int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic set_date(int y, int mo, int d, int h, int mi, int s);
        cy = y; cmo = mo; cd = d; ch = h; cmi = mi; cs = s;
        yb  = {4'(y / 1000), 4'((y / 100) % 10), 4'((y / 10) % 10), 4'(y % 10)};
        mob = bcd8(mo); db = bcd8(d); hb = bcd8(h); mib = bcd8(mi); sb = bcd8(s);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_armed[k] = 0; m_tgt[k] = 0; m_h[k] = 0; m_m[k] = 0; m_s[k] = 0;
            m_left[0][k] = 0; m_left[1][k] = 0;
        end
        m_prev = 0;
    endtask

    task automatic model_edge();
        if (rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 3; k++) begin
            if (set && sel == 2'(k)) begin
                m_armed[k] = 1;
                m_tgt[k]   = epoch(cy, cmo, cd, ch, cmi, cs);
                m_h[k] = ch; m_m[k] = cmi; m_s[k] = cs;
                m_left[0][k] = 0; m_left[1][k] = 0;
            end else if (cancel) begin
                m_left[0][k] = 0; m_left[1][k] = 0;
            end else if (m_armed[k] && cnt == m_tgt[k]) begin
                m_left[0][k] = RS[0]; m_left[1][k] = RS[1];
            end else if (cnt != m_prev) begin
                for (int d = 0; d < 2; d++) if (m_left[d][k] > 0) m_left[d][k]--;
            end
        end
        m_prev = cnt;
    endtask

    function automatic logic exp_ring(int d);
        return (m_left[d][0] > 0) || (m_left[d][1] > 0) || (m_left[d][2] > 0);
    endfunction

    task automatic check_all();
        logic [7:0] eh, em, es;
        eh = 8'h00; em = 8'h00; es = 8'h00;
        if (sel != 2'd3) begin
            eh = bcd8(m_h[sel]); em = bcd8(m_m[sel]); es = bcd8(m_s[sel]);
        end
        check("ring60", 64'(ring60), 64'(exp_ring(0)));
        check("ring5",  64'(ring5),  64'(exp_ring(1)));
        check("hour",   64'(h60), 64'(eh));
        check("minute", 64'(m60), 64'(em));
        check("second", 64'(s60), 64'(es));
        check("disp5",  64'({h5, m5, s5}), 64'({eh, em, es}));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    localparam logic [63:0] T0 = 64'd1704067200;

    initial begin : stim
        logic [7:0] exp_sec [4];
        int ring5_cycles;
        int r;
        exp_sec = '{8'h00, 8'h20, 8'h30, 8'h00};

        rst_n = 1'b1; set = 1'b0; cancel = 1'b0; sel = 2'd3; cnt = 64'd0;
        set_date(1970, 1, 1, 0, 0, 0);
        model_reset();
        repeat (2) cyc();
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            #1;
            check("rst_disp", 64'({h60, m60, s60}), 64'd0);
        end
        check("rst_ring", 64'(ring60), 64'd0);
        rst_n = 1'b0;
        repeat (3) cyc();
        check("unarmed_zero", 64'(ring60), 64'd0);

        // three slots on 2024-01-01
        for (int k = 0; k < 3; k++) begin
            sel = 2'(k);
            set_date(2024, 1, 1, 0, 0, (k == 0) ? 0 : (k == 1) ? 20 : 30);
            set = 1'b1;
            cyc();
            set = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            sel = 2'(k);
            #1;
            check("disp_sec", 64'(s60), 64'(exp_sec[k]));
        end
        sel = 2'd3;

        cnt = T0 - 64'd1;
        ring5_cycles = 0;
        for (int i = 0; i <= 36; i++) begin
            cancel = (cnt == T0 + 64'd25);
            cyc();
            if (cnt == T0 - 64'd1)  check("pre_match",   64'(ring60), 64'd0);
            if (cnt == T0)          check("match0",      64'(ring60), 64'd1);
            if (cnt == T0 + 64'd20) check("match1",      64'(ring60), 64'd1);
            if (cnt == T0 + 64'd25) check("cancel",      64'(ring60), 64'd0);
            if (cnt == T0 + 64'd26) check("post_cancel", 64'(ring60), 64'd0);
            if (cnt == T0 + 64'd30) check("match2",      64'(ring60), 64'd1);
            if (cnt >= T0 && cnt < T0 + 64'd20 && ring5) ring5_cycles++;
            cnt = cnt + 64'd1;
        end
        cancel = 1'b0;
        check("ring5_ticks", 64'(ring5_cycles), 64'd5);

        // jump over target
        cancel = 1'b1; cyc(); cancel = 1'b0;
        cnt = T0 - 64'd1; cyc();
        cnt = T0 + 64'd1; cyc();
        check("jump", 64'(ring60), 64'd0);
        cyc();
        check("jump_hold", 64'(ring60), 64'd0);

        // set on a ringing slot clears it
        cnt = T0 + 64'd20; cyc();
        check("slot1_ring", 64'(ring60), 64'd1);
        cnt = T0 + 64'd21; sel = 2'd1; set_date(2024, 1, 1, 0, 0, 20); set = 1'b1;
        cyc();
        set = 1'b0;
        check("set_clears", 64'(ring60), 64'd0);

        // asynchronous reset while ringing
        sel = 2'd3; cnt = T0 + 64'd30; cyc();
        check("pre_async", 64'(ring60), 64'd1);
        #2 rst_n = 1'b1;
        #1;
        check("async_ring60", 64'(ring60), 64'd0);
        check("async_ring5",  64'(ring5),  64'd0);
        model_reset();
        repeat (2) cyc();
        rst_n = 1'b0;
        cnt = T0 + 64'd31; cyc();
        cnt = T0 + 64'd30; cyc();
        check("disarmed", 64'(ring60), 64'd0);

        // randomized phase against the model
        for (int it = 0; it < 40; it++) begin
            int y, mo;
            y  = int'($urandom_range(1970, 2099));
            mo = int'($urandom_range(1, 12));
            set_date(y, mo, int'($urandom_range(1, mdays(mo, y))),
                     int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                     int'($urandom_range(0, 59)));
            sel = 2'($urandom_range(0, 3));
            set = 1'b1;
            cyc();
            set = 1'b0;
            cnt = epoch(cy, cmo, cd, ch, cmi, cs) - 64'($urandom_range(0, 3));
            for (int j = 0; j < 12; j++) begin
                r = int'($urandom_range(0, 11));
                cancel = (r == 9);
                sel    = (r == 10) ? 2'($urandom_range(0, 3)) : sel;
                set    = (r == 11);
                cyc();
                set = 1'b0;
                cancel = 1'b0;
                if (r <= 5 || r == 9) cnt = cnt + 64'd1;
                else if (r == 8)      cnt = cnt + 64'd2;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
